// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the dead-time inserter: leg state encoding, default sizes
// and the gate-bit index helpers.
package pwm_dt_pkg;

   localparam int NUM_LEGS_DEF = 4;
   localparam int DT_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEAD = 2'd1,
      ST_HI   = 2'd2,
      ST_LO   = 2'd3
   } leg_state_e;

   function automatic int hi_idx(input int k);
      return 2 * k;
   endfunction

   function automatic int lo_idx(input int k);
      return 2 * k + 1;
   endfunction

endpackage

// File: rtl/pwm_deadtime_gen_leg.sv
// One half-bridge leg: command-to-gate FSM with a dead-time counter that guarantees
// an all-off interval of max(dead_time,1) cycles on every transition.
module pwm_dt_leg
   import pwm_dt_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                gate_off,
   input  logic                cmd,
   input  logic [DT_WIDTH-1:0] dead_time,
   output logic                hi,
   output logic                lo
);

   localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   leg_state_e          state, state_nx;
   logic [DT_WIDTH-1:0] cnt, cnt_nx, dt_eff;
   logic                target, target_nx;

   assign dt_eff = (dead_time == '0) ? DT_ONE : dead_time;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      target_nx = target;
      case (state)
         ST_IDLE: begin
            state_nx  = ST_DEAD;
            cnt_nx    = dt_eff;
            target_nx = cmd;
         end
         ST_DEAD: begin
            // The interval length is fixed at entry; only the destination follows cmd.
            target_nx = cmd;
            if (cnt <= DT_ONE) state_nx = target ? ST_HI : ST_LO;
            else               cnt_nx   = cnt - DT_ONE;
         end
         ST_HI: begin
            if (!cmd) begin
               state_nx  = ST_DEAD;
               cnt_nx    = dt_eff;
               target_nx = cmd;
            end
         end
         ST_LO: begin
            if (cmd) begin
               state_nx  = ST_DEAD;
               cnt_nx    = dt_eff;
               target_nx = cmd;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (gate_off) begin
         state_nx  = ST_IDLE;
         cnt_nx    = '0;
         target_nx = 1'b0;
      end
   end

   // Gates are decoded from the next state so they switch on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         target <= 1'b0;
         hi     <= 1'b0;
         lo     <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         target <= target_nx;
         hi     <= (state_nx == ST_HI);
         lo     <= (state_nx == ST_LO);
      end
   end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Dead-time inserter for the H-bridge gate bus: per-leg FSMs plus fault latch.
// Optional shoot-through comparator enabled by defining PWM_DT_XCHECK_EN.
module pwm_deadtime_gen
   import pwm_dt_pkg::*;
#(
   parameter int NUM_LEGS = NUM_LEGS_DEF,
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DT_WIDTH-1:0]   dead_time,
   input  logic [NUM_LEGS-1:0]   leg_cmd,
   input  logic                  fault,
   input  logic                  fault_clr,
   output logic [2*NUM_LEGS-1:0] pwm_out,
   output logic                  fault_latched,
   output logic                  xcheck_err
);

   logic gate_off;
   logic xcheck_hit;

   assign gate_off = !enable | fault | fault_latched;

   for (genvar k = 0; k < NUM_LEGS; k++) begin : g_leg
      pwm_dt_leg #(.DT_WIDTH(DT_WIDTH)) u_leg (
         .clk       (clk),
         .rst_n     (rst_n),
         .gate_off  (gate_off),
         .cmd       (leg_cmd[k]),
         .dead_time (dead_time),
         .hi        (pwm_out[hi_idx(k)]),
         .lo        (pwm_out[lo_idx(k)])
      );
   end

`ifdef PWM_DT_XCHECK_EN
   logic [NUM_LEGS-1:0] both_on;

   // Watches the registered bus, independent of the leg FSMs.
   always_comb begin
      both_on = '0;
      for (int k = 0; k < NUM_LEGS; k++)
         both_on[k] = pwm_out[hi_idx(k)] & pwm_out[lo_idx(k)];
   end

   assign xcheck_hit = |both_on;

   always_ff @(posedge clk) begin
      if (!rst_n) xcheck_err <= 1'b0;
      else        xcheck_err <= xcheck_err | xcheck_hit;
   end
`else
   assign xcheck_hit = 1'b0;
   assign xcheck_err = 1'b0;
`endif

   // Set has priority over clear so a fault held during fault_clr stays latched.
   always_ff @(posedge clk) begin
      if (!rst_n)                   fault_latched <= 1'b0;
      else if (fault | xcheck_hit)  fault_latched <= 1'b1;
      else if (fault_clr)           fault_latched <= 1'b0;
   end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pwm_deadtime_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] dead_time;
   logic [3:0] leg_cmd;
   logic       fault;
   logic       fault_clr;
   logic [7:0] pwm_out;
   logic       fault_latched;
   logic       xcheck_err;

   typedef struct {
      logic [7:0] pwm;
      logic       fl;
      logic       xe;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vec_id   = 0;
   logic chk_inv  = 1'b0;

   always #5 clk = ~clk;

   pwm_deadtime_gen #(.NUM_LEGS(4), .DT_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .dead_time     (dead_time),
      .leg_cmd       (leg_cmd),
      .fault         (fault),
      .fault_clr     (fault_clr),
      .pwm_out       (pwm_out),
      .fault_latched (fault_latched),
      .xcheck_err    (xcheck_err)
   );

   // Monitor: one expectation per clock, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (pwm_out !== e.pwm || fault_latched !== e.fl || xcheck_err !== e.xe) begin
            failures++;
            $display("FAIL vec%0d pwm_out=%h exp=%h fault_latched=%b exp=%b xcheck_err=%b exp=%b",
                     e.id, pwm_out, e.pwm, fault_latched, e.fl, xcheck_err, e.xe);
         end
      end
      if (chk_inv) begin
         checks++;
         for (int k = 0; k < 4; k++) begin
            if (pwm_out[2*k] === 1'b1 && pwm_out[2*k+1] === 1'b1) begin
               failures++;
               $display("FAIL shoot_through leg%0d pwm_out=%h exp=both-not-high", k, pwm_out);
               break;
            end
         end
      end
   end

   // Advance one edge and record what the outputs must be after it.
   task automatic cyc(input logic [7:0] p, input logic f, input logic x);
      exp_t e;
      @(posedge clk);
      #1;
      e.pwm = p; e.fl = f; e.xe = x; e.id = vec_id;
      vec_id++;
      exp_q.push_back(e);
   endtask

   task automatic cycn(input int n, input logic [7:0] p, input logic f);
      for (int i = 0; i < n; i++) cyc(p, f, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; dead_time = 8'd5; leg_cmd = 4'b0000;
      fault = 1'b0; fault_clr = 1'b0;
      cycn(2, 8'h00, 1'b0);                 // reset state
      chk_inv = 1'b1;

      // Power-up: 5 dead cycles then all low sides.
      rst_n = 1'b1; enable = 1'b1;
      cycn(5, 8'h00, 1'b0);
      cycn(2, 8'hAA, 1'b0);

      // Leg 0 low->high with dead_time 3.
      dead_time = 8'd3; leg_cmd = 4'b0001;
      cycn(3, 8'hA8, 1'b0);
      cycn(2, 8'hA9, 1'b0);

      // dead_time 0 behaves as 1.
      dead_time = 8'd0; leg_cmd = 4'b0000;
      cyc(8'hA8, 1'b0, 1'b0);
      cyc(8'hAA, 1'b0, 1'b0);
      leg_cmd = 4'b1111;
      cyc(8'h00, 1'b0, 1'b0);
      cycn(2, 8'h55, 1'b0);

      // Leg 2 glitches 1-0-1 inside a 10-cycle dead interval.
      dead_time = 8'd10; leg_cmd = 4'b1011;
      cyc(8'h45, 1'b0, 1'b0);
      leg_cmd = 4'b1111;
      cyc(8'h45, 1'b0, 1'b0);
      leg_cmd = 4'b1011;
      cyc(8'h45, 1'b0, 1'b0);
      leg_cmd = 4'b1111;
      cycn(7, 8'h45, 1'b0);
      cycn(2, 8'h55, 1'b0);

      // Legs 1 and 3 to low side, dead_time 2.
      dead_time = 8'd2; leg_cmd = 4'b0101;
      cycn(2, 8'h11, 1'b0);
      cycn(2, 8'h99, 1'b0);

      // Fault pulse, fault+clear together, clear alone, restart through DEAD.
      fault = 1'b1;
      cyc(8'h00, 1'b1, 1'b0);
      fault = 1'b0;
      cyc(8'h00, 1'b1, 1'b0);
      fault = 1'b1; fault_clr = 1'b1;
      cyc(8'h00, 1'b1, 1'b0);
      fault = 1'b0;
      cyc(8'h00, 1'b0, 1'b0);
      fault_clr = 1'b0;
      cycn(2, 8'h00, 1'b0);
      cycn(2, 8'h99, 1'b0);

      // dead_time change mid-DEAD is ignored.
      dead_time = 8'd3; leg_cmd = 4'b0000;
      cyc(8'h88, 1'b0, 1'b0);
      dead_time = 8'd9;
      cycn(2, 8'h88, 1'b0);
      cycn(2, 8'hAA, 1'b0);

      // Disable forces all off, re-enable restarts through DEAD (dead_time 9).
      enable = 1'b0;
      cycn(2, 8'h00, 1'b0);
      enable = 1'b1;
      cycn(9, 8'h00, 1'b0);
      cyc(8'hAA, 1'b0, 1'b0);

      // Reset mid-DEAD and mid-fault.
      dead_time = 8'd4; leg_cmd = 4'b1111;
      cyc(8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      cycn(4, 8'h00, 1'b0);
      cyc(8'h55, 1'b0, 1'b0);
      fault = 1'b1;
      cyc(8'h00, 1'b1, 1'b0);
      fault = 1'b0; rst_n = 1'b0;
      cyc(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1; leg_cmd = 4'b0000;
      cycn(4, 8'h00, 1'b0);
      cyc(8'hAA, 1'b0, 1'b0);

`ifdef PWM_DT_XCHECK_EN
      // Override leg 2 gates to both-on; comparator must latch.
      @(negedge clk);
      #1;
      chk_inv = 1'b0;
      force dut.pwm_out[5:4] = 2'b11;
      cyc(8'hBA, 1'b1, 1'b1);
      cyc(8'h30, 1'b1, 1'b1);
      release dut.pwm_out[5:4];
      rst_n = 1'b0;
      cyc(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
`endif

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
